// File: rtl/data_mem_responder_pkg.sv
// rtl/data_mem_responder_pkg.sv - shared codes and helpers for the data-memory responder
package data_mem_responder_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_e;

    // Request kind as {wen, ren}; shared with the request generator.
    typedef enum logic [1:0] {
        OP_NONE  = 2'b00,
        OP_LOAD  = 2'b01,
        OP_STORE = 2'b10,
        OP_BOTH  = 2'b11
    } req_op_e;

    // Lane pattern a legal store of this width/offset must carry; 0 for an illegal store code.
    function automatic logic [3:0] store_lanes(input logic [2:0] funct3, input logic [1:0] off);
        logic [3:0] lanes;
        case (funct3)
            F3_SB:   lanes = 4'b0001 << off;
            F3_SH:   lanes = off[1] ? 4'b1100 : 4'b0011;
            F3_SW:   lanes = 4'b1111;
            default: lanes = 4'b0000;
        endcase
        return lanes;
    endfunction

endpackage

// File: rtl/data_mem_responder_load_extract.sv
// rtl/data_mem_responder_load_extract.sv - byte/halfword/word load extraction with extension
module load_extract
    import data_mem_responder_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] data,
    output logic        illegal
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (offset)
            2'd0:    byte_sel = word[7:0];
            2'd1:    byte_sel = word[15:8];
            2'd2:    byte_sel = word[23:16];
            default: byte_sel = word[31:24];
        endcase
        half_sel = offset[1] ? word[31:16] : word[15:0];

        data    = '0;
        illegal = 1'b0;
        case (funct3)
            F3_LB:   data = {{24{byte_sel[7]}}, byte_sel};
            F3_LH:   data = {{16{half_sel[15]}}, half_sel};
            F3_LW:   data = word;
            F3_LBU:  data = {24'd0, byte_sel};
            F3_LHU:  data = {16'd0, half_sel};
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - data-memory responder with wait states, byte-enabled writes and fault checks
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 1,
    parameter int AW          = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wen,
    input  logic        ren,
    input  logic [31:0] address,
    input  logic [3:0]  wstrobe,
    input  logic [31:0] wdata,
    input  logic [2:0]  funct3,
    output logic        ready,
    output logic        done,
    output logic [31:0] rdata,
    output logic        err
);

    localparam int CW = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;
    localparam logic [CW-1:0] CNT_INIT = (WAIT_STATES > 0) ? CW'(WAIT_STATES - 1) : '0;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   addr_q, addr_d;
    logic [3:0]    wstrobe_q, wstrobe_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [2:0]    funct3_q, funct3_d;
    req_op_e       op_q, op_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          err_q, err_d;

    logic [31:0]   mem [DEPTH_WORDS];

    logic          accept, commit, fault, mem_we;
    logic [31:0]   cur_addr, cur_wdata, word, ext_data;
    logic [3:0]    cur_wstrobe;
    logic [2:0]    cur_funct3;
    req_op_e       cur_op;
    logic [AW-1:0] idx;
    logic [1:0]    off;
    logic          ext_illegal;

    // With zero wait states the commit happens on the accepting edge, so it must see the live inputs.
    always_comb begin
        accept = (wen || ren) && (state_q == S_IDLE);
        if (state_q == S_IDLE) begin
            cur_addr    = address;
            cur_wstrobe = wstrobe;
            cur_wdata   = wdata;
            cur_funct3  = funct3;
            cur_op      = req_op_e'({wen, ren});
        end else begin
            cur_addr    = addr_q;
            cur_wstrobe = wstrobe_q;
            cur_wdata   = wdata_q;
            cur_funct3  = funct3_q;
            cur_op      = op_q;
        end
    end

    assign idx  = cur_addr[AW+1:2];
    assign off  = cur_addr[1:0];
    assign word = (32'(idx) < DEPTH_WORDS) ? mem[idx] : '0;

    load_extract u_extract (
        .word    (word),
        .offset  (off),
        .funct3  (cur_funct3),
        .data    (ext_data),
        .illegal (ext_illegal)
    );

    always_comb begin
        fault = 1'b0;
        if ((cur_addr[31:AW+2] != '0) || (32'(idx) >= DEPTH_WORDS)) fault = 1'b1;
        if ((cur_funct3[1:0] == 2'b10) && (off != 2'b00))           fault = 1'b1;
        if ((cur_funct3[1:0] == 2'b01) && off[0])                   fault = 1'b1;
        case (cur_op)
            OP_LOAD:  if (ext_illegal) fault = 1'b1;
            OP_STORE: if ((cur_wstrobe == 4'b0000) ||
                          (cur_wstrobe != store_lanes(cur_funct3, off))) fault = 1'b1;
            OP_BOTH:  fault = 1'b1;
            default:  ;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wstrobe_d = wstrobe_q;
        wdata_d   = wdata_q;
        funct3_d  = funct3_q;
        op_d      = op_q;
        rdata_d   = '0;
        err_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    addr_d    = address;
                    wstrobe_d = wstrobe;
                    wdata_d   = wdata;
                    funct3_d  = funct3;
                    op_d      = req_op_e'({wen, ren});
                    if (WAIT_STATES == 0) begin
                        state_d = S_RESP;
                    end else begin
                        state_d = S_BUSY;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            S_BUSY: begin
                if (cnt_q == '0) state_d = S_RESP;
                else             cnt_d   = cnt_q - 1'b1;
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // rdata/err are loaded only on the edge into RESP and clear on the way out.
        commit = (state_d == S_RESP) && (state_q != S_RESP);
        if (commit) begin
            err_d   = fault;
            rdata_d = ((cur_op == OP_LOAD) && !fault) ? ext_data : '0;
        end
        mem_we = commit && (cur_op == OP_STORE) && !fault && !rst;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            wstrobe_q <= '0;
            wdata_q   <= '0;
            funct3_q  <= '0;
            op_q      <= OP_NONE;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            wstrobe_q <= wstrobe_d;
            wdata_q   <= wdata_d;
            funct3_q  <= funct3_d;
            op_q      <= op_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
        end
    end

    // RAM contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (cur_wstrobe[i]) mem[idx][8*i +: 8] <= cur_wdata[8*i +: 8];
            end
        end
    end

    assign ready = (state_q == S_IDLE);
    assign done  = (state_q == S_RESP);
    assign rdata = rdata_q;
    assign err   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - self-checking bench for data_mem_responder at 0, 1 and 3 wait states
module tb_data_mem_responder;

    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst_a   [3];
    logic        wen_a   [3];
    logic        ren_a   [3];
    logic [31:0] addr_a  [3];
    logic [3:0]  strb_a  [3];
    logic [31:0] wdata_a [3];
    logic [2:0]  f3_a    [3];
    logic        ready_a [3];
    logic        done_a  [3];
    logic [31:0] rdata_a [3];
    logic        err_a   [3];

    logic [31:0] ref_mem [3][DEPTH];
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(1), .AW(10)) u_ws1 (
        .clk(clk), .rst(rst_a[0]), .wen(wen_a[0]), .ren(ren_a[0]), .address(addr_a[0]),
        .wstrobe(strb_a[0]), .wdata(wdata_a[0]), .funct3(f3_a[0]),
        .ready(ready_a[0]), .done(done_a[0]), .rdata(rdata_a[0]), .err(err_a[0]));

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(0), .AW(10)) u_ws0 (
        .clk(clk), .rst(rst_a[1]), .wen(wen_a[1]), .ren(ren_a[1]), .address(addr_a[1]),
        .wstrobe(strb_a[1]), .wdata(wdata_a[1]), .funct3(f3_a[1]),
        .ready(ready_a[1]), .done(done_a[1]), .rdata(rdata_a[1]), .err(err_a[1]));

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(3), .AW(10)) u_ws3 (
        .clk(clk), .rst(rst_a[2]), .wen(wen_a[2]), .ren(ren_a[2]), .address(addr_a[2]),
        .wstrobe(strb_a[2]), .wdata(wdata_a[2]), .funct3(f3_a[2]),
        .ready(ready_a[2]), .done(done_a[2]), .rdata(rdata_a[2]), .err(err_a[2]));

    function automatic int ws_of(input int inst);
        return (inst == 0) ? 1 : (inst == 1) ? 0 : 3;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Reference: legality from access size and byte offset, memory as a plain word array.
    task automatic model(input int inst, input bit w, input bit r, input logic [31:0] a,
                         input logic [3:0] s, input logic [31:0] d, input logic [2:0] f,
                         output bit e, output logic [31:0] rd);
        int sz;
        int off;
        bit valid;
        logic [31:0] v;
        e   = w && r;
        rd  = '0;
        sz  = 0;
        off = int'(a % 4);
        if (a >= 32'(4 * DEPTH)) e = 1'b1;
        valid = w ? (f <= 3'd2) : (f inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        if (!valid) begin
            e = 1'b1;
        end else begin
            sz = 1 << (f % 4);
            if (a % sz != 0) e = 1'b1;
            if (w && (s != 4'(((1 << sz) - 1) << off))) e = 1'b1;
        end
        if (e) return;
        if (w) begin
            for (int i = 0; i < 4; i++) begin
                if (s[i]) ref_mem[inst][a / 4][8*i +: 8] = d[8*i +: 8];
            end
        end else begin
            v = ref_mem[inst][a / 4] >> (8 * off);
            case (sz)
                1:       rd = f[2] ? {24'd0, v[7:0]}  : {{24{v[7]}}, v[7:0]};
                2:       rd = f[2] ? {16'd0, v[15:0]} : {{16{v[15]}}, v[15:0]};
                default: rd = v;
            endcase
        end
    endtask

    // Entered at a falling edge; returns at the falling edge where done is seen, request still driven.
    task automatic access(input int inst, input bit w, input bit r, input logic [31:0] a,
                          input logic [3:0] s, input logic [31:0] d, input logic [2:0] f,
                          output logic [31:0] got, output time t_done);
        bit e_exp;
        logic [31:0] rd_exp;
        int cyc;
        wen_a[inst]   = w;
        ren_a[inst]   = r;
        addr_a[inst]  = a;
        strb_a[inst]  = s;
        wdata_a[inst] = d;
        f3_a[inst]    = f;
        cyc = 0;
        while (!ready_a[inst] && cyc < 8) begin
            @(negedge clk);
            cyc++;
        end
        check("ready_idle", ready_a[inst], 1'b1);
        model(inst, w, r, a, s, d, f, e_exp, rd_exp);
        @(posedge clk);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (!done_a[inst]) check("ready_busy", ready_a[inst], 1'b0);
        end while (!done_a[inst] && cyc < 16);
        check("done_latency", cyc, ws_of(inst) + 1);
        check("ready_resp", ready_a[inst], 1'b0);
        check("err", err_a[inst], e_exp);
        if (r || e_exp) check("rdata", rdata_a[inst], rd_exp);
        got    = rdata_a[inst];
        t_done = $time;
    endtask

    task automatic idle(input int inst);
        wen_a[inst] = 1'b0;
        ren_a[inst] = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] got, data, a;
        logic [3:0]  s;
        logic [2:0]  f;
        time         t, t_prev;
        int          seen, kind, sz;
        logic [31:0] pool [8];
        pool = '{32'h010, 32'h014, 32'h190, 32'h3FC, 32'h7FC, 32'hC80, 32'hFF8, 32'hFFC};

        for (int i = 0; i < 3; i++) begin
            rst_a[i] = 1'b1; wen_a[i] = 1'b0; ren_a[i] = 1'b0; addr_a[i] = '0;
            strb_a[i] = '0; wdata_a[i] = '0; f3_a[i] = '0;
        end
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check("rst_ready", ready_a[i], 1'b1);
            check("rst_done", done_a[i], 1'b0);
            check("rst_rdata", rdata_a[i], 32'h0);
            check("rst_err", err_a[i], 1'b0);
            rst_a[i] = 1'b0;
        end
        @(negedge clk);

        // Directed sequence, one wait state
        access(0, 1, 0, 32'h10, 4'b1111, 32'hDEADBEEF, 3'b010, got, t); idle(0);
        access(0, 0, 1, 32'h10, 4'b0000, 32'h0, 3'b010, got, t); idle(0);
        check("lw_10", got, 32'hDEADBEEF);
        access(0, 0, 1, 32'h13, 4'b0000, 32'h0, 3'b000, got, t); idle(0);
        check("lb_13", got, 32'hFFFFFFDE);
        access(0, 0, 1, 32'h13, 4'b0000, 32'h0, 3'b100, got, t); idle(0);
        check("lbu_13", got, 32'h000000DE);
        access(0, 0, 1, 32'h12, 4'b0000, 32'h0, 3'b001, got, t); idle(0);
        check("lh_12", got, 32'hFFFFDEAD);
        access(0, 0, 1, 32'h10, 4'b0000, 32'h0, 3'b101, got, t); idle(0);
        check("lhu_10", got, 32'h0000BEEF);
        access(0, 1, 0, 32'h11, 4'b0010, 32'h00005500, 3'b000, got, t); idle(0);
        access(0, 0, 1, 32'h10, 4'b0000, 32'h0, 3'b010, got, t); idle(0);
        check("lw_after_sb", got, 32'hDEAD55EF);
        access(0, 1, 0, 32'h12, 4'b1100, 32'h12340000, 3'b001, got, t); idle(0);
        access(0, 0, 1, 32'h10, 4'b0000, 32'h0, 3'b010, got, t); idle(0);
        check("lw_after_sh", got, 32'h123455EF);

        // Faulting accesses; the model supplies err=1, rdata=0
        access(0, 0, 1, 32'h02, 4'b0000, 32'h0, 3'b010, got, t); idle(0);
        access(0, 0, 1, 32'h01, 4'b0000, 32'h0, 3'b001, got, t); idle(0);
        access(0, 1, 0, 32'(4 * DEPTH), 4'b1111, 32'hCAFEF00D, 3'b010, got, t); idle(0);
        access(0, 1, 1, 32'h10, 4'b1111, 32'hCAFEF00D, 3'b010, got, t); idle(0);
        access(0, 1, 0, 32'h10, 4'b0010, 32'h0000AA00, 3'b000, got, t); idle(0);
        access(0, 0, 1, 32'h10, 4'b0000, 32'h0, 3'b010, got, t); idle(0);
        check("lw_after_faults", got, 32'h123455EF);

        // Zero wait states: alternating SW/LW held back-to-back, including the top word
        t_prev = 0;
        for (int k = 0; k < 6; k++) begin
            a    = (k == 5) ? 32'(4 * DEPTH - 4) : pool[k];
            data = $urandom;
            access(1, 1, 0, a, 4'b1111, data, 3'b010, got, t);
            if (k > 0) check("b2b_sw_spacing", 32'(t - t_prev), 32'd20);
            t_prev = t;
            access(1, 0, 1, a, 4'b0000, 32'h0, 3'b010, got, t);
            check("b2b_lw_spacing", 32'(t - t_prev), 32'd20);
            check("b2b_lw_data", got, data);
            t_prev = t;
        end
        idle(1);

        // Randomized traffic against the reference model on both short-latency instances
        for (int inst = 0; inst < 2; inst++) begin
            for (int p = 0; p < 8; p++) begin
                access(inst, 1, 0, pool[p], 4'b1111, $urandom, 3'b010, got, t);
                idle(inst);
            end
            for (int n = 0; n < 60; n++) begin
                kind = $urandom_range(0, 11);
                a    = pool[$urandom_range(0, 7)] + 32'($urandom_range(0, 3));
                if (kind == 0) a = a | 32'h0010_0000;
                if ($urandom_range(0, 5) == 0) f = 3'($urandom);
                else if (kind < 5) f = 3'($urandom_range(0, 2));
                else f = 3'($urandom_range(0, 4) == 3 ? 5 : $urandom_range(0, 4));
                sz = 1 << (f % 4);
                s  = 4'(((1 << sz) - 1) << (a % 4));
                if ($urandom_range(0, 5) == 0) s = 4'($urandom);
                access(inst, kind < 5, kind == 1 || kind >= 5, a, s, $urandom, f, got, t);
                if ($urandom_range(0, 1) == 0) idle(inst);
            end
            idle(inst);
        end

        // Reset while a store is in BUSY: it must neither commit nor complete
        access(2, 1, 0, 32'h20, 4'b1111, 32'h11223344, 3'b010, got, t); idle(2);
        wen_a[2] = 1'b1; ren_a[2] = 1'b0; addr_a[2] = 32'h20; strb_a[2] = 4'b1111;
        wdata_a[2] = 32'hA5A5A5A5; f3_a[2] = 3'b010;
        check("abort_ready_idle", ready_a[2], 1'b1);
        @(posedge clk);
        @(negedge clk);
        check("abort_ready_busy", ready_a[2], 1'b0);
        rst_a[2] = 1'b1;
        #1;
        check("abort_ready_rst", ready_a[2], 1'b1);
        check("abort_done_rst", done_a[2], 1'b0);
        wen_a[2] = 1'b0;
        @(negedge clk);
        rst_a[2] = 1'b0;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (done_a[2]) seen++;
        end
        check("abort_no_done", seen, 0);
        access(2, 0, 1, 32'h20, 4'b0000, 32'h0, 3'b010, got, t); idle(2);
        check("abort_kept_old", got, 32'h11223344);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Responder end of the core's data-memory interface: consumes the wen/ren/wstrobe request produced by the load/store stage, plus address, write data and funct3.
- Performs byte-enabled writes and aligned, sign- or zero-extended reads on an internal word-organised memory.
- Inserts a programmable number of wait states and signals completion with a one-cycle done pulse.
- Sits between the core's MEM stage and the data-side RAM macro. The macro is modelled internally as an array.

Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words; valid byte range is 0 .. 4*DEPTH_WORDS-1.
- WAIT_STATES, 1: BUSY cycles between acceptance and response; 0 is legal.
- AW, 10: word-index width; must equal clog2(DEPTH_WORDS).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- wen  in  1  store request.
- ren  in  1  load request.
- address  in  32  byte address.
- wstrobe  in  4  byte lanes; bit i enables byte i of the word.
- wdata  in  32  store data, already lane-positioned.
- funct3  in  3  load/store width code.
- ready  out  1  high only in IDLE; a request is accepted on a cycle with (wen|ren) && ready.
- done  out  1  one-cycle pulse in RESP.
- rdata  out  32  extracted load data; valid only while done is high on a load.
- err  out  1  valid with done; flags a faulted access.

Behaviour:
- Reset (async, any state): state=IDLE, ready=1, done=0, rdata=0, err=0, captured request cleared. An uncommitted write is dropped. Memory contents are not reset.
- FSM:
  - IDLE -> BUSY on accept when WAIT_STATES>0, loading wait counter = WAIT_STATES-1.
  - IDLE -> RESP on accept when WAIT_STATES=0.
  - BUSY: counter decrements each cycle; BUSY -> RESP when counter==0.
  - RESP -> IDLE unconditionally.
- Capture: address, wstrobe, wdata, funct3, wen, ren are registered on the accepting edge. Inputs are ignored outside IDLE.
- Latency: done is high exactly WAIT_STATES+1 cycles after the accept cycle.
- Throughput: one access per WAIT_STATES+2 cycles; ready is low in BUSY and RESP.
- Commit point: a write commits, and read data is sampled, on the edge entering RESP. rdata and err are registered and held only during RESP; otherwise rdata=0 and err=0.
- Write: for each i with wstrobe[i]=1, mem[address[AW+1:2]] byte i = wdata byte i. Other bytes are unchanged.
- Read extraction. Word w = mem[index]; off = address[1:0].
  - LB 000: sign-extend byte off.
  - LH 001: sign-extend halfword address[1].
  - LW 010: w unchanged.
  - LBU 100: zero-extend byte off.
  - LHU 101: zero-extend halfword address[1].
  - Any other funct3: err.
- Error conditions. Each one gives err=1 with done, no memory write, rdata=0:
  - wen && ren both high at accept (still accepted).
  - Word index >= DEPTH_WORDS, or address[31:AW+2] != 0.
  - Word access with off != 0.
  - Halfword access with address[0]=1.
  - Store with wstrobe=0000.
  - Store whose wstrobe does not match funct3/offset: SB requires 0001<<off; SH requires 0011 or 1100 per address[1]; SW requires 1111.
- Back-to-back: a request held high through RESP is accepted again in the following IDLE cycle. The master deasserts wen/ren after seeing done.
- Reset during BUSY: no commit occurs, and no done is ever produced for that request.

Decomposition:
- params.vh holds:
  - funct3 codes (LB/LH/LW/LBU/LHU, SB/SH/SW);
  - FSM state encodings S_IDLE, S_BUSY, S_RESP (2 bits);
  - the STORE/LOAD opcodes, shared with the request generator.
- Sub-module load_extract (combinational): inputs word, offset, funct3; outputs extracted data and an illegal-funct3 flag. It is reused by any future cache path.
- FSM, counter, memory array and error check stay in the top module.

Test Plan:
- WAIT_STATES=1. SW addr 0x10 wdata 0xDEADBEEF, then LW 0x10 -> done exactly 2 cycles after each accept; LW rdata=0xDEADBEEF, err=0; ready low for 2 cycles after each accept.
- Byte and halfword loads on word 0x10=0xDEADBEEF:
  - LB 0x13 -> 0xFFFFFFDE.
  - LBU 0x13 -> 0x000000DE.
  - LH 0x12 -> 0xFFFFDEAD.
  - LHU 0x10 -> 0x0000BEEF.
- Partial store: SB 0x11 wstrobe 0010 wdata 0x00005500 over 0xDEADBEEF -> LW 0x10 = 0xDEAD55EF. Then SH 0x12 wstrobe 1100 wdata 0x12340000 -> LW 0x10 = 0x123455EF.
- Fault cases, all with err=1 and memory unchanged:
  - LW 0x02.
  - LH 0x01.
  - SW at byte 4*DEPTH_WORDS.
  - wen=ren=1.
  - SB 0x10 with wstrobe 0010.
- WAIT_STATES=0 instance: continuous alternating SW/LW -> done every 2nd cycle, data correct; max-address word 4*DEPTH_WORDS-4 read/write passes.
- Assert rst during BUSY of SW 0x20 data 0xA5A5A5A5 (WAIT_STATES=3). Then:
  - no done pulse for the interrupted request;
  - ready=1 immediately;
  - LW 0x20 returns the prior contents, not 0xA5A5A5A5.
